// File: rtl/riscv_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_pkg
// Description : Shared constants, buffer entry type and PC alignment helper
//               for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_fetch_pkg;

    localparam int              XLEN             = 32;
    localparam int              INST_BYTES       = 4;
    localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One buffered fetch: the instruction word and the PC it was read from.
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Force a byte address onto an instruction-word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~(XLEN'(INST_BYTES - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO holding fetched instructions.
//               Head entry is driven straight from storage flops. Flush
//               empties the buffer and wins over a same-cycle push.
// Ports       : clk, rst (async, active-high)
//               flush              - discard all entries
//               push / push_data   - write one entry
//               pop                - drop head entry (ignored when empty)
//               head_data          - entry at the head
//               count/empty/full   - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q, count_d;
    logic               w_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        w_pop    = pop & (count_q != '0);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            count_d = count_q + c_cnt_w'(push) - c_cnt_w'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == c_cnt_w'(DEPTH));

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch-side initiator of the instruction memory. Holds the PC,
//               issues word reads (1-cycle read latency), buffers returned
//               words with their PC and hands them to decode over a
//               valid/ready handshake. Redirects reload the PC and flush.
// Ports       : clk, rst (async, active-high)
//               mem_read_address/mem_read_enable - read request (PC, issue)
//               mem_instruction                  - read data, one cycle later
//               inst_valid/inst_ready            - decode handshake
//               inst_data/inst_pc                - head instruction and PC
//               redirect_valid/redirect_pc       - new PC, flush
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] mem_read_address,
    output logic        mem_read_enable,
    input  logic [31:0] mem_instruction,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
    localparam int c_occ_w = c_cnt_w + 1;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [c_occ_w-1:0] w_credits_used;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head_entry;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    always_comb begin
        w_pop = ~w_fifo_empty & inst_ready;

        // Slots already spoken for: buffered entries plus the read in flight,
        // minus the entry decode takes this cycle. A new read is only issued
        // when its response is guaranteed a slot.
        w_credits_used = c_occ_w'(w_fifo_count) + c_occ_w'(inflight_q)
                       - c_occ_w'(w_pop);
        w_issue = ~rst & ~redirect_valid
                & (w_credits_used < c_occ_w'(FIFO_DEPTH));

        // A response arriving in a redirect cycle belongs to the old stream.
        w_push            = inflight_q & ~redirect_valid;
        w_push_entry.inst = mem_instruction;
        w_push_entry.pc   = inflight_pc_q;

        pc_d          = pc_q;
        inflight_d    = w_issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
        end else if (w_issue) begin
            pc_d          = pc_q + PC_STEP;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head_entry),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty),
        .full      (w_fifo_full)
    );

    // The credit check must make a push into a full, non-draining buffer
    // impossible.
    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_fifo_full && !w_pop));

    assign mem_read_address = pc_q;
    assign mem_read_enable  = w_issue;
    assign inst_valid       = ~w_fifo_empty;
    assign inst_data        = w_head_entry.inst;
    assign inst_pc          = w_head_entry.pc;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Self-checking bench for instruction_fetch: directed latency,
//               stall, redirect, wrap and reset scenarios plus a randomized
//               run against a sequential-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_read_address;
    logic        mem_read_enable;
    logic [31:0] mem_instruction = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    // Second instance with a reset PC near the top of the address space.
    logic [31:0] w_addr;
    logic        w_en;
    logic [31:0] w_instr = '0;
    logic        w_valid;
    logic [31:0] w_data;
    logic [31:0] w_pc;
    logic        w_redirect_valid = 1'b0;
    logic [31:0] w_redirect_pc = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read_address (mem_read_address),
        .mem_read_enable  (mem_read_enable),
        .mem_instruction  (mem_instruction),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
        .clk              (clk),
        .rst              (rst),
        .mem_read_address (w_addr),
        .mem_read_enable  (w_en),
        .mem_instruction  (w_instr),
        .inst_valid       (w_valid),
        .inst_ready       (inst_ready),
        .inst_data        (w_data),
        .inst_pc          (w_pc),
        .redirect_valid   (w_redirect_valid),
        .redirect_pc      (w_redirect_pc)
    );

    // Memory image: the four preloaded words, a scrambled pattern elsewhere.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0013;
            32'h4:   return 32'h0010_0093;
            32'h8:   return 32'h0020_0113;
            32'hC:   return 32'h0030_0193;
            default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // One-cycle synchronous read memories.
    always @(posedge clk) if (mem_read_enable) mem_instruction <= memf(mem_read_address);
    always @(posedge clk) if (w_en) w_instr <= memf(w_addr);

    // Hold reset for a couple of cycles; return at the negedge that starts
    // cycle 0 (first cycle with rst low).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b1;
        @(negedge clk);
        #2;
        total++;
        if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%h pc=%h want v=0 d=0 pc=0", inst_valid, inst_data, inst_pc);
        end
        total++;
        if (mem_read_enable !== 1'b0 || mem_read_address !== 32'h0) begin
            bad++;
            $display("FAIL reset_mem got en=%b addr=%h want en=0 addr=0", mem_read_enable, mem_read_address);
        end
        total++;
        if (w_en !== 1'b0 || w_addr !== 32'hFFFF_FFF8) begin
            bad++;
            $display("FAIL reset_wrap_mem got en=%b addr=%h want en=0 addr=fffffff8", w_en, w_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] want_pc;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            #2;
            total++;
            if (mem_read_enable !== 1'b1 || mem_read_address !== 32'(4 * i)) begin
                bad++;
                $display("FAIL stream_issue cyc=%0d got en=%b addr=%h want en=1 addr=%h",
                         i, mem_read_enable, mem_read_address, 32'(4 * i));
            end
            total++;
            if (inst_valid !== (i >= 2)) begin
                bad++;
                $display("FAIL stream_valid cyc=%0d got %b want %b", i, inst_valid, (i >= 2));
            end
            if (i >= 2) begin
                want_pc = 32'(4 * (i - 2));
                total++;
                if (inst_pc !== want_pc || inst_data !== memf(want_pc)) begin
                    bad++;
                    $display("FAIL stream_data cyc=%0d got pc=%h d=%h want pc=%h d=%h",
                             i, inst_pc, inst_data, want_pc, memf(want_pc));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [31:0] want_pc;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            inst_ready = !(i >= 2 && i <= 6);
            #2;
            if (i >= 2 && i <= 6) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== memf(32'h0)) begin
                    bad++;
                    $display("FAIL stall_head cyc=%0d got v=%b pc=%h d=%h want v=1 pc=0 d=%h",
                             i, inst_valid, inst_pc, inst_data, memf(32'h0));
                end
                total++;
                if (mem_read_enable !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_issue cyc=%0d got en=%b want en=0", i, mem_read_enable);
                end
            end
            if (i == 7) begin
                total++;
                if (mem_read_enable !== 1'b1 || mem_read_address !== 32'h8) begin
                    bad++;
                    $display("FAIL stall_resume_issue got en=%b addr=%h want en=1 addr=8",
                             mem_read_enable, mem_read_address);
                end
            end
            if (i >= 7) begin
                want_pc = 32'(4 * (i - 7));
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== want_pc || inst_data !== memf(want_pc)) begin
                    bad++;
                    $display("FAIL stall_release cyc=%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             i, inst_valid, inst_pc, inst_data, want_pc, memf(want_pc));
                end
            end
            @(negedge clk);
        end
        inst_ready = 1'b1;
    endtask

    // Redirect at cycle 3 to target tgt; ready low around it when no_pop.
    task automatic test_redirect(input logic [31:0] tgt, input bit no_pop, input string tag);
        logic [31:0] base;
        base = tgt & 32'hFFFF_FFFC;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            inst_ready     = no_pop ? !(i == 2 || i == 3) : 1'b1;
            redirect_valid = (i == 3);
            redirect_pc    = (i == 3) ? tgt : 32'h0;
            #2;
            if (i == 3) begin
                total++;
                if (mem_read_enable !== 1'b0) begin
                    bad++;
                    $display("FAIL %s_r_issue got en=%b want en=0", tag, mem_read_enable);
                end
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== (no_pop ? 32'h0 : 32'h4)) begin
                    bad++;
                    $display("FAIL %s_r_head got v=%b pc=%h want v=1 pc=%h",
                             tag, inst_valid, inst_pc, (no_pop ? 32'h0 : 32'h4));
                end
            end
            if (i == 4 || i == 5) begin
                total++;
                if (inst_valid !== 1'b0 || mem_read_enable !== 1'b1 ||
                    mem_read_address !== base + 32'(4 * (i - 4))) begin
                    bad++;
                    $display("FAIL %s_gap cyc=%0d got v=%b en=%b addr=%h want v=0 en=1 addr=%h",
                             tag, i, inst_valid, mem_read_enable, mem_read_address, base + 32'(4 * (i - 4)));
                end
            end
            if (i >= 6) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== base + 32'(4 * (i - 6)) ||
                    inst_data !== memf(base + 32'(4 * (i - 6)))) begin
                    bad++;
                    $display("FAIL %s_resume cyc=%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             tag, i, inst_valid, inst_pc, inst_data,
                             base + 32'(4 * (i - 6)), memf(base + 32'(4 * (i - 6))));
                end
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
    endtask

    task automatic test_wrap();
        logic [31:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            want = 32'hFFFF_FFF8 + 32'(4 * i);
            #2;
            total++;
            if (w_en !== 1'b1 || w_addr !== want) begin
                bad++;
                $display("FAIL wrap_issue cyc=%0d got en=%b addr=%h want en=1 addr=%h", i, w_en, w_addr, want);
            end
            if (i >= 2) begin
                want = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
                total++;
                if (w_valid !== 1'b1 || w_pc !== want || w_data !== memf(want)) begin
                    bad++;
                    $display("FAIL wrap_data cyc=%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             i, w_valid, w_pc, w_data, want, memf(want));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            redirect_valid = (i == 0);
            redirect_pc    = 32'h40;
            if (i < 3) @(negedge clk);
        end
        #2;
        total++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
            bad++;
            $display("FAIL midrst_pre got v=%b pc=%h want v=1 pc=40", inst_valid, inst_pc);
        end
        rst = 1'b1;
        #1;
        total++;
        if (inst_valid !== 1'b0 || mem_read_enable !== 1'b0 || mem_read_address !== 32'h0) begin
            bad++;
            $display("FAIL midrst_immediate got v=%b en=%b addr=%h want v=0 en=0 addr=0",
                     inst_valid, mem_read_enable, mem_read_address);
        end
        @(negedge clk);
        rst = 1'b0; inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            if (i == 0) begin
                total++;
                if (mem_read_enable !== 1'b1 || mem_read_address !== 32'h0) begin
                    bad++;
                    $display("FAIL midrst_restart got en=%b addr=%h want en=1 addr=0",
                             mem_read_enable, mem_read_address);
                end
            end
            total++;
            if (inst_valid !== (i >= 2) || (i >= 2 && inst_pc !== 32'(4 * (i - 2)))) begin
                bad++;
                $display("FAIL midrst_stream cyc=%0d got v=%b pc=%h want v=%b pc=%h",
                         i, inst_valid, inst_pc, (i >= 2), 32'(4 * (i - 2)));
            end
            @(negedge clk);
        end
    endtask

    // Reference: decode must see one contiguous word-stepped stream starting
    // at the last redirect target, nothing for two cycles after a redirect,
    // and a stable head while stalled.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] hold_pc;
        logic [31:0] hold_data;
        int          blank;
        int          pops;
        bit          held;
        exp_pc = 32'h0; blank = 0; pops = 0; held = 1'b0;
        hold_pc = '0; hold_data = '0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            inst_ready     = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 29) == 0);
            redirect_pc    = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            #2;
            if (blank > 0) begin
                total++;
                if (inst_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_flush cyc=%0d got v=%b pc=%h want v=0", i, inst_valid, inst_pc);
                end
                blank--;
            end
            if (held) begin
                total++;
                if (inst_valid !== 1'b1 || inst_pc !== hold_pc || inst_data !== hold_data) begin
                    bad++;
                    $display("FAIL rand_hold cyc=%0d got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             i, inst_valid, inst_pc, inst_data, hold_pc, hold_data);
                end
            end
            if (inst_valid === 1'b1 && inst_ready) begin
                total++;
                if (inst_pc !== exp_pc || inst_data !== memf(exp_pc)) begin
                    bad++;
                    $display("FAIL rand_pop cyc=%0d got pc=%h d=%h want pc=%h d=%h",
                             i, inst_pc, inst_data, exp_pc, memf(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            held      = (inst_valid === 1'b1) && !inst_ready && !redirect_valid;
            hold_pc   = inst_pc;
            hold_data = inst_data;
            if (redirect_valid) begin
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
                blank  = 2;
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        total++;
        if (pops < 100) begin
            bad++;
            $display("FAIL rand_progress got pops=%0d want at least 100", pops);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect(32'h8, 1'b1, "redirect");
        test_redirect(32'h7, 1'b0, "redirect_pop");
        test_wrap();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
